ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Owns both ports of the shared dual-port buffer RAM and hands them between the PCIe DMA engine and the custom processing logic. It sits directly downstream of the custom logic: it consumes the custom read and write port signals, drives the custom enable and reset, and routes the selected master onto the RAM. A run starts when the DMA has filled the buffer. The block then gives the RAM to the custom logic, counts result writes up to a programmed length, and returns ownership to the DMA with a completion interrupt, or with a timeout error.

## Interface
- W_ADDR, 12, RAM address width
- W_DATA, 128, RAM data width
- TIMEOUT_CYC, 4096, max RUN cycles allowed without a custom write; must be > 2
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- dma_start  in  1  one-cycle pulse: buffer filled, begin run
- dma_len  in  W_ADDR+1  result words expected, sampled on accepted dma_start
- dma_wr_addr, dma_rd_addr  in  W_ADDR  DMA port a/b address
- dma_wren_a, dma_rden_b  in  1  DMA write/read strobes
- dma_wr_data  in  W_DATA  DMA write data
- dma_rd_data  out  W_DATA  RAM port b data to DMA
- custom_wr_addr, custom_rd_addr  in  W_ADDR  custom port a/b address
- custom_wren_a, custom_rden_b  in  1  custom write/read strobes
- custom_wr_data  in  W_DATA  custom write data
- custom_rd_data  out  W_DATA  RAM port b data to custom logic
- custom_en  out  1  custom logic enable
- custom_rst  out  1  custom logic reset, active-high pulse
- ram_addr_a, ram_addr_b  out  W_ADDR  RAM addresses
- ram_wren_a, ram_rden_b  out  1  RAM strobes
- ram_data_a  out  W_DATA  RAM write data
- ram_q_b  in  W_DATA  RAM port b read data
- busy  out  1  custom logic owns RAM
- done_irq  out  1  one-cycle pulse at run end
- timeout_err  out  1  sticky: last run ended by timeout
- dma_collision  out  1  sticky: DMA strobed while not owner
- wr_count  out  W_ADDR+1  custom writes counted in current/last run

## Operation
- FSM states: DMA_OWN, CLR, RUN, DRAIN, DONE. Reset state is DMA_OWN.
- DMA_OWN: the DMA owns the RAM.
  - On dma_start: latch dma_len, clear wr_count, timeout_err and dma_collision, then go to CLR.
- CLR: drive custom_rst=1 for exactly one cycle, then go to RUN.
  - If the latched len==0, go to DONE instead and skip RUN.
- RUN: the custom logic owns the RAM and custom_en=1.
  - Each custom_wren_a increments wr_count.
  - When the increment makes wr_count==len, go to DRAIN.
  - A watchdog counter resets on every custom write. When it reaches TIMEOUT_CYC, set timeout_err and go to DRAIN.
- DRAIN: custom_en=0, the custom logic still owns the RAM, and custom strobes still pass through. Hold for 2 cycles to cover RAM read latency and in-flight writes, then go to DONE.
  - Writes accepted in DRAIN are counted, but wr_count saturates at 2^(W_ADDR+1)-1.
- DONE: done_irq=1 for one cycle, ownership returns to the DMA, then go to DMA_OWN.
- Owner mux:
  - The owner select is a registered bit: custom in CLR/RUN/DRAIN, DMA otherwise.
  - The non-owner's strobes are forced to 0 on the RAM.
  - ram_q_b is fanned out to both custom_rd_data and dma_rd_data unconditionally.
- dma_wren_a or dma_rden_b asserted while the custom logic owns the RAM:
  - the access is dropped and dma_collision is set;
  - it stays set until the next accepted dma_start.
- dma_start outside DMA_OWN is ignored and does not set any flag.
- busy=1 in CLR, RUN and DRAIN.

## Timing
- Reset values:
  - state DMA_OWN and owner DMA;
  - custom_en=0, custom_rst=0, busy=0, done_irq=0, timeout_err=0, dma_collision=0, wr_count=0;
  - RAM strobes 0.
- Address and data outputs are combinational through the mux from the registered owner bit. Zero-cycle passthrough latency.
- dma_start at edge N: CLR during N+1 (custom_rst high), RUN from N+2 (custom_en high).
- Final counted write at edge M: DRAIN during M+1 and M+2, done_irq during M+3, DMA owns the RAM from M+3.
- Timeout: TIMEOUT_CYC cycles in RUN with no custom write. Then DRAIN and DONE follow with the same 2+1 cycle tail.
- rst_n asserted mid-run: immediate return to DMA_OWN with all outputs at reset values. There is no done_irq, and the custom logic is left disabled.
- A custom write and the timeout expiring in the same cycle: the write counts, the watchdog resets, and there is no timeout.

## Structure
- Shared package: FSM state encoding and the DRAIN_CYC=2 constant.
- Sub-module ram_port_mux: the combinational two-master to RAM mux, selected by the owner bit.
- The FSM, counters and flags live in ram_port_arbiter.

## Test plan
- dma_len=4; the custom logic writes 4 words at addresses 0..3 → custom_rst pulse at N+1, custom_en at N+2, wr_count=4, done_irq 3 cycles after the 4th write, RAM contents correct.
- dma_len=0 → CLR, then DONE: done_irq at N+2, custom_en never high.
- TIMEOUT_CYC=16; the custom logic never writes → timeout_err=1, done_irq at cycle N+2+16+3, wr_count=0.
- DMA asserts dma_wren_a during RUN → ram_wren_a follows the custom logic only, dma_collision=1; next dma_start clears the flag.
- dma_start pulsed during RUN → ignored, latched len unchanged.
- rst_n low in RUN with wr_count=2 → all outputs at reset values within the same cycle, no done_irq.

Source files
------------

// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and constants for the buffer RAM port arbiter.
// Holds the ownership FSM encoding and the drain length.
package ram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    DMA_OWN,
    CLR,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int DRAIN_CYC = 2;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// RAM-side bus bundle: the DMA port, the custom port and the RAM port.
// The slave modport is the arbiter; the master modport is everything else.
interface ram_port_arbiter_if #(
  parameter int W_ADDR = 12,
  parameter int W_DATA = 128
);
  logic [W_ADDR-1:0] dma_wr_addr;
  logic [W_ADDR-1:0] dma_rd_addr;
  logic              dma_wren_a;
  logic              dma_rden_b;
  logic [W_DATA-1:0] dma_wr_data;
  logic [W_DATA-1:0] dma_rd_data;

  logic [W_ADDR-1:0] custom_wr_addr;
  logic [W_ADDR-1:0] custom_rd_addr;
  logic              custom_wren_a;
  logic              custom_rden_b;
  logic [W_DATA-1:0] custom_wr_data;
  logic [W_DATA-1:0] custom_rd_data;

  logic [W_ADDR-1:0] ram_addr_a;
  logic [W_ADDR-1:0] ram_addr_b;
  logic              ram_wren_a;
  logic              ram_rden_b;
  logic [W_DATA-1:0] ram_data_a;
  logic [W_DATA-1:0] ram_q_b;

  modport slave (
    input  dma_wr_addr, dma_rd_addr,
    input  dma_wren_a, dma_rden_b, dma_wr_data,
    output dma_rd_data,
    input  custom_wr_addr, custom_rd_addr,
    input  custom_wren_a, custom_rden_b, custom_wr_data,
    output custom_rd_data,
    output ram_addr_a, ram_addr_b,
    output ram_wren_a, ram_rden_b, ram_data_a,
    input  ram_q_b
  );

  modport master (
    output dma_wr_addr, dma_rd_addr,
    output dma_wren_a, dma_rden_b, dma_wr_data,
    input  dma_rd_data,
    output custom_wr_addr, custom_rd_addr,
    output custom_wren_a, custom_rden_b, custom_wr_data,
    input  custom_rd_data,
    input  ram_addr_a, ram_addr_b,
    input  ram_wren_a, ram_rden_b, ram_data_a,
    output ram_q_b
  );

endinterface

// File: rtl/ram_port_mux.sv
// Two-master to RAM mux; the non-owner's strobes never reach the RAM.
// Read data fans out to both masters regardless of ownership.
module ram_port_mux #(
  parameter int W_ADDR = 12,
  parameter int W_DATA = 128
) (
  input  logic              sel_custom,
  input  logic [W_ADDR-1:0] dma_wr_addr,
  input  logic [W_ADDR-1:0] dma_rd_addr,
  input  logic              dma_wren_a,
  input  logic              dma_rden_b,
  input  logic [W_DATA-1:0] dma_wr_data,
  input  logic [W_ADDR-1:0] custom_wr_addr,
  input  logic [W_ADDR-1:0] custom_rd_addr,
  input  logic              custom_wren_a,
  input  logic              custom_rden_b,
  input  logic [W_DATA-1:0] custom_wr_data,
  input  logic [W_DATA-1:0] ram_q_b,
  output logic [W_ADDR-1:0] ram_addr_a,
  output logic [W_ADDR-1:0] ram_addr_b,
  output logic              ram_wren_a,
  output logic              ram_rden_b,
  output logic [W_DATA-1:0] ram_data_a,
  output logic [W_DATA-1:0] dma_rd_data,
  output logic [W_DATA-1:0] custom_rd_data
);

  assign ram_addr_a = sel_custom ? custom_wr_addr : dma_wr_addr;
  assign ram_addr_b = sel_custom ? custom_rd_addr : dma_rd_addr;
  assign ram_data_a = sel_custom ? custom_wr_data : dma_wr_data;
  assign ram_wren_a = sel_custom ? custom_wren_a : dma_wren_a;
  assign ram_rden_b = sel_custom ? custom_rden_b : dma_rden_b;

  assign dma_rd_data    = ram_q_b;
  assign custom_rd_data = ram_q_b;

endmodule

// File: rtl/ram_port_arbiter.sv
// Hands the shared buffer RAM between the DMA engine and custom logic.
// Runs the ownership FSM, result-write counter, watchdog and flags.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int W_ADDR      = 12,
  parameter int W_DATA      = 128,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_start,
  input  logic [W_ADDR:0]   dma_len,
  ram_port_arbiter_if.slave bus,
  output logic              custom_en,
  output logic              custom_rst,
  output logic              busy,
  output logic              done_irq,
  output logic              timeout_err,
  output logic              dma_collision,
  output logic [W_ADDR:0]   wr_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  state_e          state;
  logic            owner;
  logic [W_ADDR:0] len;
  logic [WD_W-1:0] wdog;
  logic [1:0]      dcnt;
  logic            dma_hit;
  logic            hit_len;
  logic            hit_wd;

  assign dma_hit = bus.dma_wren_a | bus.dma_rden_b;
  assign hit_len = bus.custom_wren_a &&
                   (wr_count + 1'b1 == len);
  // a write in the expiry cycle wins over the watchdog
  assign hit_wd  = !bus.custom_wren_a &&
                   (wdog == WD_W'(TIMEOUT_CYC));

  ram_port_mux #(
    .W_ADDR (W_ADDR),
    .W_DATA (W_DATA)
  ) u_mux (
    .sel_custom     (owner),
    .dma_wr_addr    (bus.dma_wr_addr),
    .dma_rd_addr    (bus.dma_rd_addr),
    .dma_wren_a     (bus.dma_wren_a),
    .dma_rden_b     (bus.dma_rden_b),
    .dma_wr_data    (bus.dma_wr_data),
    .custom_wr_addr (bus.custom_wr_addr),
    .custom_rd_addr (bus.custom_rd_addr),
    .custom_wren_a  (bus.custom_wren_a),
    .custom_rden_b  (bus.custom_rden_b),
    .custom_wr_data (bus.custom_wr_data),
    .ram_q_b        (bus.ram_q_b),
    .ram_addr_a     (bus.ram_addr_a),
    .ram_addr_b     (bus.ram_addr_b),
    .ram_wren_a     (bus.ram_wren_a),
    .ram_rden_b     (bus.ram_rden_b),
    .ram_data_a     (bus.ram_data_a),
    .dma_rd_data    (bus.dma_rd_data),
    .custom_rd_data (bus.custom_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= DMA_OWN;
      owner         <= 1'b0;
      custom_en     <= 1'b0;
      custom_rst    <= 1'b0;
      busy          <= 1'b0;
      done_irq      <= 1'b0;
      timeout_err   <= 1'b0;
      dma_collision <= 1'b0;
      wr_count      <= '0;
      len           <= '0;
      wdog          <= '0;
      dcnt          <= '0;
    end else begin
      done_irq   <= 1'b0;
      custom_rst <= 1'b0;
      if (owner && dma_hit) dma_collision <= 1'b1;
      unique case (state)
        DMA_OWN: begin
          if (dma_start) begin
            len           <= dma_len;
            wr_count      <= '0;
            timeout_err   <= 1'b0;
            dma_collision <= 1'b0;
            state         <= CLR;
            owner         <= 1'b1;
            busy          <= 1'b1;
            custom_rst    <= 1'b1;
          end
        end
        CLR: begin
          wdog <= '0;
          dcnt <= '0;
          if (len == '0) begin
            state    <= DONE;
            owner    <= 1'b0;
            busy     <= 1'b0;
            done_irq <= 1'b1;
          end else begin
            state     <= RUN;
            custom_en <= 1'b1;
          end
        end
        RUN: begin
          if (bus.custom_wren_a) begin
            wr_count <= wr_count + 1'b1;
            wdog     <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
          if (hit_wd) timeout_err <= 1'b1;
          if (hit_len || hit_wd) begin
            state     <= DRAIN;
            custom_en <= 1'b0;
            dcnt      <= '0;
          end
        end
        DRAIN: begin
          if (bus.custom_wren_a && wr_count != '1)
            wr_count <= wr_count + 1'b1;
          if (dcnt == 2'(DRAIN_CYC - 1)) begin
            state    <= DONE;
            owner    <= 1'b0;
            busy     <= 1'b0;
            done_irq <= 1'b1;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        DONE: state <= DMA_OWN;
        default: state <= DMA_OWN;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_ram_port_arbiter;

  localparam int WA = 12;
  localparam int WD = 128;

  logic          clk;
  logic          rst_n;
  logic          dma_start;
  logic [WA:0]   dma_len;
  logic          custom_en;
  logic          custom_rst;
  logic          busy;
  logic          done_irq;
  logic          timeout_err;
  logic          dma_collision;
  logic [WA:0]   wr_count;
  logic [WD-1:0] mem [16];
  int            checks;
  int            errors;

  ram_port_arbiter_if #(.W_ADDR(WA), .W_DATA(WD)) bus ();

  ram_port_arbiter #(
    .W_ADDR      (WA),
    .W_DATA      (WD),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dma_start     (dma_start),
    .dma_len       (dma_len),
    .bus           (bus.slave),
    .custom_en     (custom_en),
    .custom_rst    (custom_rst),
    .busy          (busy),
    .done_irq      (done_irq),
    .timeout_err   (timeout_err),
    .dma_collision (dma_collision),
    .wr_count      (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n && checks == 0) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (bus.ram_wren_a) begin
      mem[bus.ram_addr_a[3:0]] <= bus.ram_data_a;
    end
    if (bus.ram_rden_b) bus.ram_q_b <= mem[bus.ram_addr_b[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start(input int n);
    dma_start = 1'b1;
    dma_len   = (WA+1)'(n);
    tick();
    dma_start = 1'b0;
  endtask

  task automatic cwr(input int a, input logic [WD-1:0] d);
    bus.custom_wren_a  = 1'b1;
    bus.custom_wr_addr = WA'(a);
    bus.custom_wr_data = d;
  endtask

  task automatic chk(input string tag,
                     input logic [WD-1:0] obs,
                     input logic [WD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    dma_start = 1'b0;
    dma_len = '0;
    bus.dma_wr_addr = '0;
    bus.dma_rd_addr = '0;
    bus.dma_wren_a = 1'b0;
    bus.dma_rden_b = 1'b0;
    bus.dma_wr_data = '0;
    bus.custom_wr_addr = '0;
    bus.custom_rd_addr = '0;
    bus.custom_wren_a = 1'b0;
    bus.custom_rden_b = 1'b0;
    bus.custom_wr_data = '0;
    bus.ram_q_b = '0;
    ticks(2);
    chk("rst_busy", busy, 0);
    chk("rst_en", custom_en, 0);
    chk("rst_crst", custom_rst, 0);
    chk("rst_done", done_irq, 0);
    chk("rst_wc", wr_count, 0);
    chk("rst_wren", bus.ram_wren_a, 0);
    rst_n = 1'b1;
    tick();

    // four result writes, len 4
    start(4);
    chk("t1_crst", custom_rst, 1);
    chk("t1_en0", custom_en, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_en", custom_en, 1);
    chk("t1_crst0", custom_rst, 0);
    for (int i = 0; i < 4; i++) begin
      cwr(i, {120'hA5, 8'(i)});
      tick();
    end
    bus.custom_wren_a = 1'b0;
    chk("t1_wc", wr_count, 4);
    chk("t1_drain_en", custom_en, 0);
    chk("t1_drain_busy", busy, 1);
    chk("t1_drain_done", done_irq, 0);
    tick();
    chk("t1_done_early", done_irq, 0);
    tick();
    chk("t1_done", done_irq, 1);
    chk("t1_busy0", busy, 0);
    bus.dma_rden_b = 1'b1;
    bus.dma_rd_addr = 12'd2;
    tick();
    bus.dma_rden_b = 1'b0;
    chk("t1_done_pulse", done_irq, 0);
    chk("t1_dma_rd", bus.dma_rd_data, {120'hA5, 8'h02});
    chk("t1_cus_rd", bus.custom_rd_data, {120'hA5, 8'h02});
    for (int i = 0; i < 4; i++)
      chk("t1_mem", mem[i], {120'hA5, 8'(i)});

    // zero length goes straight to DONE
    start(0);
    chk("t2_crst", custom_rst, 1);
    tick();
    chk("t2_done", done_irq, 1);
    chk("t2_en", custom_en, 0);
    chk("t2_busy", busy, 0);
    tick();

    // DMA collision and ignored restart, len 3
    start(3);
    tick();
    cwr(4, 128'h44);
    bus.dma_wren_a = 1'b1;
    bus.dma_wr_addr = 12'd5;
    bus.dma_wr_data = 128'h55;
    dma_start = 1'b1;
    dma_len = 13'd1;
    #1;
    chk("t3_mux_wren", bus.ram_wren_a, 1);
    chk("t3_mux_addr", bus.ram_addr_a, 4);
    chk("t3_mux_data", bus.ram_data_a, 128'h44);
    tick();
    dma_start = 1'b0;
    bus.dma_wren_a = 1'b0;
    chk("t3_coll", dma_collision, 1);
    chk("t3_wc1", wr_count, 1);
    chk("t3_crst", custom_rst, 0);
    chk("t3_en1", custom_en, 1);
    cwr(6, 128'h66);
    tick();
    chk("t3_wc2", wr_count, 2);
    chk("t3_en2", custom_en, 1);
    cwr(7, 128'h77);
    tick();
    chk("t3_wc3", wr_count, 3);
    chk("t3_drain", custom_en, 0);
    cwr(8, 128'h88);
    tick();
    bus.custom_wren_a = 1'b0;
    chk("t3_drain_wr", wr_count, 4);
    tick();
    chk("t3_done", done_irq, 1);
    chk("t3_coll_hold", dma_collision, 1);
    chk("t3_mem4", mem[4], 128'h44);
    chk("t3_mem5", mem[5], 128'h0);
    chk("t3_mem8", mem[8], 128'h88);
    tick();

    // watchdog expiry with no writes
    start(4);
    chk("t4_coll_clr", dma_collision, 0);
    tick();
    chk("t4_en", custom_en, 1);
    ticks(16);
    chk("t4_pre_to", timeout_err, 0);
    chk("t4_pre_en", custom_en, 1);
    tick();
    chk("t4_to", timeout_err, 1);
    chk("t4_drain", custom_en, 0);
    tick();
    chk("t4_done_early", done_irq, 0);
    tick();
    chk("t4_done", done_irq, 1);
    chk("t4_wc", wr_count, 0);
    tick();

    // write lands in the expiry cycle
    start(2);
    chk("t5_to_clr", timeout_err, 0);
    ticks(17);
    cwr(9, 128'h99);
    tick();
    chk("t5_wc1", wr_count, 1);
    chk("t5_no_to", timeout_err, 0);
    chk("t5_en", custom_en, 1);
    cwr(10, 128'hAA);
    tick();
    bus.custom_wren_a = 1'b0;
    chk("t5_drain", custom_en, 0);
    chk("t5_wc2", wr_count, 2);
    ticks(2);
    chk("t5_done", done_irq, 1);
    chk("t5_to_end", timeout_err, 0);
    tick();

    // reset in the middle of a run
    start(4);
    tick();
    cwr(11, 128'hBB);
    bus.custom_rden_b = 1'b1;
    ticks(2);
    chk("t6_wc", wr_count, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_en", custom_en, 0);
    chk("t6_crst", custom_rst, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done_irq, 0);
    chk("t6_coll", dma_collision, 0);
    chk("t6_wc0", wr_count, 0);
    chk("t6_wren", bus.ram_wren_a, 0);
    chk("t6_rden", bus.ram_rden_b, 0);
    ticks(4);
    chk("t6_no_irq", done_irq, 0);
    chk("t6_en_off", custom_en, 0);
    bus.custom_wren_a = 1'b0;
    bus.custom_rden_b = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
